// File: rtl/fir_host_loader.sv
// Purpose  : host-side sequencer; turns one valid/ready word stream (NTAPS coefficients then
//            NSAMP samples) into addressed FIR memory writes, runs the FIR and captures its result.
// Latency  : each accepted word appears as a write strobe the following cycle; fir_s rises the
//            cycle after the final sample strobe. res_valid follows fir_done by one cycle.
// Backpressure: in_ready is high for the whole load phase, so back-to-back words are accepted
//            one per cycle. The FIR memory interface has no backpressure.
// Ports    : clk/rstn (async active-low), start, in_data/in_valid/in_ready (word stream),
//            fir_addr/fir_din/fir_cload/fir_dload (active-low write strobes), fir_s/fir_done/
//            fir_dout (run handshake), res_data/res_valid (result), busy, err (sticky timeout).
module fir_host_loader #(
   parameter int NTAPS   = 64,
   parameter int NSAMP   = 16384,
   parameter int DW      = 16,
   parameter int AW      = 14,      // must satisfy 2**AW >= NSAMP
   parameter int TIMEOUT = 1048576  // 0 disables the RUN timeout
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          start,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [AW-1:0] fir_addr,
   output logic [DW-1:0] fir_din,
   output logic          fir_cload,
   output logic          fir_dload,
   output logic          fir_s,
   input  logic          fir_done,
   input  logic [DW-1:0] fir_dout,
   output logic [DW-1:0] res_data,
   output logic          res_valid,
   output logic          busy,
   output logic          err
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOADC   = 3'd1;
   localparam logic [2:0] S_LOADD   = 3'd2;
   localparam logic [2:0] S_RUN     = 3'd3;
   localparam logic [2:0] S_RELEASE = 3'd4;

   localparam logic [AW-1:0] LAST_C   = AW'(NTAPS - 1);
   localparam logic [AW-1:0] LAST_D   = AW'(NSAMP - 1);
   localparam logic [31:0]   TMO_LAST = 32'(TIMEOUT - 1);

   logic [2:0]    state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [31:0]   tmo_q, tmo_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] din_q, din_d;
   logic          cload_q, cload_d;
   logic          dload_q, dload_d;
   logic          s_q, s_d;
   logic [DW-1:0] res_q, res_d;
   logic          rv_q, rv_d;
   logic          rdy_q, rdy_d;
   logic          busy_q, busy_d;
   logic          err_q, err_d;
   logic          hs;

   // in_ready is registered from the next state, so it always matches the current state
   assign hs = in_valid && rdy_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
      addr_d  = addr_q;
      din_d   = din_q;
      cload_d = 1'b1;
      dload_d = 1'b1;
      s_d     = s_q;
      res_d   = res_q;
      rv_d    = 1'b0;
      err_d   = err_q;

      case (state_q)
         S_IDLE: begin
            s_d = 1'b0;
            if (start) begin
               state_d = S_LOADC;
               err_d   = 1'b0;
               cnt_d   = '0;
            end
         end
         S_LOADC: begin
            if (hs) begin
               addr_d  = cnt_q;
               din_d   = in_data;
               cload_d = 1'b0;
               if (cnt_q == LAST_C) begin
                  cnt_d   = '0;
                  state_d = S_LOADD;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_LOADD: begin
            if (hs) begin
               addr_d  = cnt_q;
               din_d   = in_data;
               dload_d = 1'b0;
               if (cnt_q == LAST_D) begin
                  cnt_d   = '0;
                  tmo_d   = '0;
                  state_d = S_RUN;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_RUN: begin
            // first RUN cycle still carries the final sample strobe; fir_s rises after it
            s_d   = 1'b1;
            tmo_d = tmo_q + 1'b1;
            if (fir_done) begin
               res_d   = fir_dout;
               rv_d    = 1'b1;
               s_d     = 1'b0;
               state_d = S_RELEASE;
            end else if ((TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
               err_d   = 1'b1;
               s_d     = 1'b0;
               state_d = S_RELEASE;
            end
         end
         S_RELEASE: begin
            s_d = 1'b0;
            if (!fir_done) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            s_d     = 1'b0;
         end
      endcase

      rdy_d  = (state_d == S_LOADC) || (state_d == S_LOADD);
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         tmo_q   <= '0;
         addr_q  <= '0;
         din_q   <= '0;
         cload_q <= 1'b1;
         dload_q <= 1'b1;
         s_q     <= 1'b0;
         res_q   <= '0;
         rv_q    <= 1'b0;
         rdy_q   <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         cload_q <= cload_d;
         dload_q <= dload_d;
         s_q     <= s_d;
         res_q   <= res_d;
         rv_q    <= rv_d;
         rdy_q   <= rdy_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   assign in_ready  = rdy_q;
   assign fir_addr  = addr_q;
   assign fir_din   = din_q;
   assign fir_cload = cload_q;
   assign fir_dload = dload_q;
   assign fir_s     = s_q;
   assign res_data  = res_q;
   assign res_valid = rv_q;
   assign busy      = busy_q;
   assign err       = err_q;

endmodule

// File: tb/tb_fir_host_loader.sv
// Directed bench for fir_host_loader with a small configuration (4 taps, 8 samples,
// 16-cycle timeout). Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_fir_host_loader;

   localparam int DW      = 16;
   localparam int AW      = 14;
   localparam int NTAPS   = 4;
   localparam int NSAMP   = 8;
   localparam int TIMEOUT = 16;

   logic          clk = 1'b0;
   logic          rstn;
   logic          start;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] fir_addr;
   logic [DW-1:0] fir_din;
   logic          fir_cload;
   logic          fir_dload;
   logic          fir_s;
   logic          fir_done;
   logic [DW-1:0] fir_dout;
   logic [DW-1:0] res_data;
   logic          res_valid;
   logic          busy;
   logic          err;

   always #5 clk = ~clk;

   fir_host_loader #(
      .NTAPS(NTAPS), .NSAMP(NSAMP), .DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rstn(rstn), .start(start),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .fir_addr(fir_addr), .fir_din(fir_din),
      .fir_cload(fir_cload), .fir_dload(fir_dload),
      .fir_s(fir_s), .fir_done(fir_done), .fir_dout(fir_dout),
      .res_data(res_data), .res_valid(res_valid), .busy(busy), .err(err)
   );

   // all outputs packed: in_ready, addr, din, cload, dload, s, res_data, res_valid, busy, err
   logic [52:0] ovec;
   assign ovec = {in_ready, fir_addr, fir_din, fir_cload, fir_dload, fir_s,
                  res_data, res_valid, busy, err};
   localparam logic [52:0] RST_VEC = {1'b0, 14'd0, 16'd0, 1'b1, 1'b1, 1'b0,
                                      16'd0, 1'b0, 1'b0, 1'b0};

   int n_chk  = 0;
   int n_fail = 0;

   // passive monitor: write counts, result pulses and strobe-exclusivity violations
   int n_wr   = 0;
   int n_res  = 0;
   int n_viol = 0;
   always @(negedge clk) begin
      if (rstn) begin
         if (!fir_cload) n_wr++;
         if (!fir_dload) n_wr++;
         if (!fir_cload && !fir_dload) n_viol++;
         if (fir_s && (!fir_cload || !fir_dload)) n_viol++;
         if (res_valid) n_res++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int wr0;
      rstn = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
      fir_done = 1'b0; fir_dout = '0;
      repeat (3) step();
      n_chk++;
      if (ovec !== RST_VEC) begin
         n_fail++;
         $display("FAIL reset_values: got %h want %h", ovec, RST_VEC);
      end
      rstn = 1'b1;
      in_valid = 1'b1; in_data = 16'hA5A5;
      wr0 = n_wr;
      for (int c = 0; c < 20; c++) begin
         step();
         n_chk++;
         if (ovec !== RST_VEC) begin
            n_fail++;
            $display("FAIL idle_values cycle %0d: got %h want %h", c, ovec, RST_VEC);
         end
      end
      in_valid = 1'b0;
      step();
      n_chk++;
      if (n_wr - wr0 !== 0) begin
         n_fail++;
         $display("FAIL idle_no_writes: got %0d writes want 0", n_wr - wr0);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
      n_chk++;
      if ({in_ready, busy, err} !== 3'b110) begin
         n_fail++;
         $display("FAIL start_accept: got rdy/busy/err=%b want 110", {in_ready, busy, err});
      end
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] ea;
      logic          ec;
      pulse_start();
      for (int i = 0; i < 12; i++) begin
         in_data = 16'(i + 1); in_valid = 1'b1;
         step();
         ec = (i < 4) ? 1'b0 : 1'b1;
         ea = (i < 4) ? AW'(i) : AW'(i - 4);
         n_chk++;
         if ({fir_cload, fir_dload, fir_addr, fir_din, in_ready, fir_s} !==
             {ec, ~ec, ea, 16'(i + 1), (i < 11) ? 1'b1 : 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_write %0d: got c=%b d=%b a=%0d din=%h rdy=%b s=%b want c=%b a=%0d din=%h",
                     i, fir_cload, fir_dload, fir_addr, fir_din, in_ready, fir_s, ec, ea, 16'(i + 1));
         end
      end
      in_valid = 1'b0;
      step();
      n_chk++;
      if ({fir_s, fir_cload, fir_dload, in_ready} !== 4'b1110) begin
         n_fail++;
         $display("FAIL b2b_run_start: got s/c/d/rdy=%b want 1110",
                  {fir_s, fir_cload, fir_dload, in_ready});
      end
   endtask

   // entered in the second RUN cycle
   task automatic test_run_done();
      int r0;
      r0 = n_res;
      repeat (8) step();
      n_chk++;
      if ({fir_s, res_valid, busy} !== 3'b101) begin
         n_fail++;
         $display("FAIL run_wait: got s/rv/busy=%b want 101", {fir_s, res_valid, busy});
      end
      fir_done = 1'b1; fir_dout = 16'hBEEF;
      step();
      fir_dout = 16'h1234;
      n_chk++;
      if ({res_valid, res_data, fir_s, busy, err} !== {1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL run_result: got rv=%b data=%h s=%b busy=%b err=%b want 1 beef 0 1 0",
                  res_valid, res_data, fir_s, busy, err);
      end
      for (int c = 0; c < 2; c++) begin
         step();
         n_chk++;
         if ({res_valid, res_data, fir_s, busy} !== {1'b0, 16'hBEEF, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL release_hold %0d: got rv=%b data=%h s=%b busy=%b want 0 beef 0 1",
                     c, res_valid, res_data, fir_s, busy);
         end
      end
      fir_done = 1'b0;
      step();
      n_chk++;
      if ({busy, in_ready, fir_s} !== 3'b000) begin
         n_fail++;
         $display("FAIL release_idle: got busy/rdy/s=%b want 000", {busy, in_ready, fir_s});
      end
      n_chk++;
      if (n_res - r0 !== 1) begin
         n_fail++;
         $display("FAIL res_pulses: got %0d want 1", n_res - r0);
      end
   endtask

   // in_valid alternates; start raised during a gap must be ignored
   task automatic test_toggle();
      logic [AW-1:0] ea;
      logic          ec;
      int            wr0;
      pulse_start();
      wr0 = n_wr;
      for (int i = 0; i < 12; i++) begin
         ec = (i < 4) ? 1'b0 : 1'b1;
         ea = (i < 4) ? AW'(i) : AW'(i - 4);
         in_data = 16'(i + 1); in_valid = 1'b1;
         step();
         n_chk++;
         if ({fir_cload, fir_dload, fir_addr, fir_din, fir_s} !== {ec, ~ec, ea, 16'(i + 1), 1'b0}) begin
            n_fail++;
            $display("FAIL toggle_write %0d: got c=%b d=%b a=%0d din=%h s=%b want c=%b a=%0d din=%h",
                     i, fir_cload, fir_dload, fir_addr, fir_din, fir_s, ec, ea, 16'(i + 1));
         end
         in_valid = 1'b0; in_data = 16'hFFFF;
         if (i == 5) start = 1'b1;
         step();
         start = 1'b0;
         n_chk++;
         if ({fir_cload, fir_dload, fir_addr, fir_din, in_ready} !==
             {2'b11, ea, 16'(i + 1), (i < 11) ? 1'b1 : 1'b0}) begin
            n_fail++;
            $display("FAIL toggle_gap %0d: got c=%b d=%b a=%0d din=%h rdy=%b want 11 a=%0d din=%h",
                     i, fir_cload, fir_dload, fir_addr, fir_din, in_ready, ea, 16'(i + 1));
         end
      end
      n_chk++;
      if (n_wr - wr0 !== 12) begin
         n_fail++;
         $display("FAIL toggle_write_count: got %0d want 12", n_wr - wr0);
      end
   endtask

   // entered in the second RUN cycle with fir_done held low
   task automatic test_timeout();
      int r0;
      r0 = n_res;
      for (int c = 2; c < 16; c++) begin
         step();
         n_chk++;
         if ({fir_s, err, busy} !== 3'b101) begin
            n_fail++;
            $display("FAIL timeout_wait run cycle %0d: got s/err/busy=%b want 101", c + 1, {fir_s, err, busy});
         end
      end
      step();
      n_chk++;
      if ({err, fir_s, res_valid, busy} !== 4'b1001) begin
         n_fail++;
         $display("FAIL timeout_fire: got err/s/rv/busy=%b want 1001", {err, fir_s, res_valid, busy});
      end
      step();
      n_chk++;
      if ({err, busy} !== 2'b10) begin
         n_fail++;
         $display("FAIL timeout_idle: got err/busy=%b want 10", {err, busy});
      end
      n_chk++;
      if (n_res - r0 !== 0) begin
         n_fail++;
         $display("FAIL timeout_no_result: got %0d pulses want 0", n_res - r0);
      end
      pulse_start();
   endtask

   // entered in LOADC (from the start that cleared err)
   task automatic test_reset_mid();
      for (int i = 0; i < 10; i++) begin
         in_data = 16'(16'h0100 + i); in_valid = 1'b1;
         step();
      end
      n_chk++;
      if ({fir_dload, fir_addr} !== {1'b0, 14'd5}) begin
         n_fail++;
         $display("FAIL mid_pre_reset: got d=%b a=%0d want d=0 a=5", fir_dload, fir_addr);
      end
      rstn = 1'b0;
      #1;
      n_chk++;
      if (ovec !== RST_VEC) begin
         n_fail++;
         $display("FAIL mid_async_reset: got %h want %h", ovec, RST_VEC);
      end
      in_valid = 1'b0;
      step();
      rstn = 1'b1;
      step();
      pulse_start();
      in_data = 16'h0055; in_valid = 1'b1;
      step();
      n_chk++;
      if ({fir_cload, fir_dload, fir_addr, fir_din} !== {2'b01, 14'd0, 16'h0055}) begin
         n_fail++;
         $display("FAIL reload_first: got c=%b d=%b a=%0d din=%h want c=0 d=1 a=0 din=0055",
                  fir_cload, fir_dload, fir_addr, fir_din);
      end
      in_data = 16'h0066;
      step();
      in_valid = 1'b0;
      n_chk++;
      if ({fir_cload, fir_addr, fir_din} !== {1'b0, 14'd1, 16'h0066}) begin
         n_fail++;
         $display("FAIL reload_second: got c=%b a=%0d din=%h want c=0 a=1 din=0066",
                  fir_cload, fir_addr, fir_din);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_run_done();
      test_toggle();
      test_timeout();
      test_reset_mid();
      n_chk++;
      if (n_viol !== 0) begin
         n_fail++;
         $display("FAIL strobe_exclusive: got %0d violations want 0", n_viol);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
